scie_pipelined: RTL and testbench
=================================

Name: scie_pipelined

Overview:
- Pipelined SCIE (custom-instruction) complex FIR accelerator attached to the core's custom-opcode datapath.
- Instructions load complex tap coefficients, push complex samples into a delay line, and read the filtered output.
- Samples and results are signed 16-bit real/imag pairs.
- The result is returned through a registered rd port.

Parameters:
- NTAPS, 3, number of FIR taps (coefficient registers and delay-line depth).
- DW, 16, bit width of each real/imag component.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- io_valid  input  1  instruction valid this cycle.
- io_insn  input  32  instruction word; only bits [6:0] (opcode) are decoded.
- io_rs1_real  input  DW  signed real part of operand rs1 (coefficient or sample).
- io_rs1_imag  input  DW  signed imag part of operand rs1.
- io_rs2  input  32  unsigned tap index for coefficient writes; ignored otherwise.
- io_rd_real  output  DW  signed real part of the registered result.
- io_rd_imag  output  DW  signed imag part of the registered result.

Behaviour:
- Reset (async, active-high): clears all coefficients c[0..NTAPS-1], delay line x[0..NTAPS-1] and rd to 0. Outputs read 0 until the first read instruction.
- Decode is valid only when io_valid=1. When io_valid=0, no state changes.
- Opcode 0x0B (SETCOEF): at the clock edge, c[io_rs2] <= (rs1_real, rs1_imag). If io_rs2 >= NTAPS the write is ignored.
- Opcode 0x2B (PUSH): at the clock edge, the delay line shifts: x[k] <= x[k-1] for k>=1, and x[0] <= rs1. The oldest sample is discarded.
- Opcode 0x5B (READ): at the clock edge, rd <= y, where y = sum over k of c[k]*x[k] (complex multiply).
  - y_real = sum(cr*xr - ci*xi).
  - y_imag = sum(cr*xi + ci*xr).
  - y is computed combinationally from current register state; a READ does not modify the delay line.
- Any other opcode with valid=1 is ignored. rd holds its value between READs.
- Latency: a READ issued in cycle N makes rd visible after edge N, i.e. during cycle N+1. A PUSH or SETCOEF issued in cycle N is reflected in a READ issued in cycle N+1 or later.
- Arithmetic:
  - Products are full precision (2*DW bits).
  - Accumulation uses at least 2*DW + ceil(log2(2*NTAPS)) bits.
  - The result is truncated to the low DW bits (two's-complement wrap) unless the optional feature is enabled.
- Empty delay-line slots hold 0, so the first outputs after reset are partial sums.
- Only one instruction per cycle exists, so there are no simultaneous-event cases.
- Reset asserted mid-sequence immediately clears all state, including rd.

Optional Feature:
- Macro: SCIE_SATURATE_EN.
- When defined: each of y_real and y_imag is clamped to [-2^(DW-1), 2^(DW-1)-1] before being registered into rd.
- When undefined: low-DW-bit wraparound.

Test Plan:
- Reset, then with no instructions: io_rd_real=0, io_rd_imag=0.
- Load coefficients:
  - SETCOEF idx0=(29,9), idx1=(-1,36), idx2=(-15,32).
  - PUSH (-4,30), idle cycle, READ: the next cycle shows rd=(-386,834).
- Continue from the previous scenario:
  - PUSH (-5,9), READ -> (-1302,42).
  - PUSH (-28,-44), READ -> (-1635,-2295).
  - PUSH (50,18), READ -> (2687,-287). Confirms the oldest sample is dropped after NTAPS.
- Further pushes on the same coefficients:
  - PUSH (10,-18) -> (1582,1114).
  - PUSH (-42,48) -> (-2338,2722).
  - PUSH (25,-5) -> (-490,-890).
  - Cycles with io_valid=0, or unknown opcodes, leave rd and all state unchanged.
- SETCOEF with io_rs2=3 (NTAPS=3) is ignored; a subsequent READ still gives the result from the unchanged coefficients.
- Overflow case: c0=(32767,0), PUSH (2,0), READ.
  - Without the macro: rd_real = -2 (wrap).
  - With SCIE_SATURATE_EN: rd_real = 32767.
  - rd_imag = 0 in both cases.

Source files
------------

// File: rtl/scie_pipelined.sv
// scie_pipelined: complex FIR custom-instruction unit with coefficient load, sample push and registered read.
// Define SCIE_SATURATE_EN to clamp results to the signed DW-bit range instead of wrapping.
module scie_pipelined #(
  parameter int NTAPS = 3,
  parameter int DW    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_valid,
  input  logic [31:0]          io_insn,
  input  logic signed [DW-1:0] io_rs1_real,
  input  logic signed [DW-1:0] io_rs1_imag,
  input  logic [31:0]          io_rs2,
  output logic signed [DW-1:0] io_rd_real,
  output logic signed [DW-1:0] io_rd_imag
);
  localparam int AW = 2*DW + $clog2(2*NTAPS) + 1;
  localparam int IW = NTAPS > 1 ? $clog2(NTAPS) : 1;
  localparam logic [6:0] OP_SET = 7'h0B, OP_PUSH = 7'h2B, OP_READ = 7'h5B;
  logic signed [DW-1:0] cr_q [NTAPS];
  logic signed [DW-1:0] ci_q [NTAPS];
  logic signed [DW-1:0] xr_q [NTAPS];
  logic signed [DW-1:0] xi_q [NTAPS];
  logic signed [DW-1:0] rd_real_q, rd_imag_q, rd_real_d, rd_imag_d;
  logic signed [AW-1:0] yr, yi, ar, ai, br, bi;
  logic do_set, do_push, do_read;
  assign do_set  = io_valid && io_insn[6:0] == OP_SET && io_rs2 < 32'(NTAPS);
  assign do_push = io_valid && io_insn[6:0] == OP_PUSH;
  assign do_read = io_valid && io_insn[6:0] == OP_READ;
  // Operands are widened before multiplying so products and sums keep full precision.
  always_comb begin
    yr = '0;
    yi = '0;
    ar = '0;
    ai = '0;
    br = '0;
    bi = '0;
    for (int k = 0; k < NTAPS; k++) begin
      ar = AW'(cr_q[k]);
      ai = AW'(ci_q[k]);
      br = AW'(xr_q[k]);
      bi = AW'(xi_q[k]);
      yr = yr + ar*br - ai*bi;
      yi = yi + ar*bi + ai*br;
    end
  end
`ifdef SCIE_SATURATE_EN
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  always_comb begin
    rd_real_d = !do_read ? rd_real_q : yr > MAXV ? MAXV[DW-1:0] : yr < MINV ? MINV[DW-1:0] : yr[DW-1:0];
    rd_imag_d = !do_read ? rd_imag_q : yi > MAXV ? MAXV[DW-1:0] : yi < MINV ? MINV[DW-1:0] : yi[DW-1:0];
  end
`else
  always_comb begin
    rd_real_d = do_read ? yr[DW-1:0] : rd_real_q;
    rd_imag_d = do_read ? yi[DW-1:0] : rd_imag_q;
  end
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        cr_q[k] <= '0;
        ci_q[k] <= '0;
        xr_q[k] <= '0;
        xi_q[k] <= '0;
      end
      rd_real_q <= '0;
      rd_imag_q <= '0;
    end else begin
      if (do_set) begin
        cr_q[io_rs2[IW-1:0]] <= io_rs1_real;
        ci_q[io_rs2[IW-1:0]] <= io_rs1_imag;
      end
      if (do_push) begin
        for (int k = NTAPS-1; k > 0; k--) begin
          xr_q[k] <= xr_q[k-1];
          xi_q[k] <= xi_q[k-1];
        end
        xr_q[0] <= io_rs1_real;
        xi_q[0] <= io_rs1_imag;
      end
      rd_real_q <= rd_real_d;
      rd_imag_q <= rd_imag_d;
    end
  end
  assign io_rd_real = rd_real_q;
  assign io_rd_imag = rd_imag_q;
endmodule

// File: tb/tb_scie_pipelined.sv
// tb_scie_pipelined: directed-vector bench for scie_pipelined.
module tb_scie_pipelined;
  localparam logic [6:0] OP_SET = 7'h0B, OP_PUSH = 7'h2B, OP_READ = 7'h5B, OP_BAD = 7'h7B;
  logic clock = 0, reset = 1, io_valid = 0;
  logic [31:0] io_insn = '0, io_rs2 = '0;
  logic signed [15:0] io_rs1_real = '0, io_rs1_imag = '0, io_rd_real, io_rd_imag;
  int compared = 0, mismatched = 0;
  scie_pipelined dut (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_insn(io_insn),
    .io_rs1_real(io_rs1_real), .io_rs1_imag(io_rs1_imag), .io_rs2(io_rs2),
    .io_rd_real(io_rd_real), .io_rd_imag(io_rd_imag)
  );
  always #5 clock = ~clock;
  task automatic step(input logic v, input logic [6:0] op, input int r, input int i, input logic [31:0] idx);
    io_valid = v;
    io_insn = {25'h1ABCDE, op};
    io_rs1_real = 16'(r);
    io_rs1_imag = 16'(i);
    io_rs2 = idx;
    @(posedge clock);
    #1;
    io_valid = 0;
    io_insn = '0;
  endtask
  task automatic chk(input string tag, input logic signed [15:0] er, input logic signed [15:0] ei);
    compared++;
    assert (io_rd_real === er) else begin
      mismatched++;
      $error("FAIL %s real: got %0d want %0d", tag, io_rd_real, er);
    end
    compared++;
    assert (io_rd_imag === ei) else begin
      mismatched++;
      $error("FAIL %s imag: got %0d want %0d", tag, io_rd_imag, ei);
    end
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("reset", 0, 0);
    repeat (3) step(0, OP_READ, 0, 0, 0);
    chk("idle_after_reset", 0, 0);
    step(1, OP_SET, 29, 9, 0);
    step(1, OP_SET, -1, 36, 1);
    step(1, OP_SET, -15, 32, 2);
    step(1, OP_PUSH, -4, 30, 0);
    step(0, OP_PUSH, 0, 0, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push1", -386, 834);
    step(1, OP_PUSH, -5, 9, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push2", -1302, 42);
    step(1, OP_PUSH, -28, -44, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push3", -1635, -2295);
    step(1, OP_PUSH, 50, 18, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push4_drop_oldest", 2687, -287);
    step(1, OP_PUSH, 10, -18, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push5", 1582, 1114);
    step(1, OP_PUSH, -42, 48, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push6", -2338, 2722);
    step(1, OP_PUSH, 25, -5, 0);
    step(1, OP_READ, 0, 0, 0);
    chk("push7", -490, -890);
    step(0, OP_PUSH, 999, 999, 0);
    step(0, OP_SET, 500, 500, 0);
    step(0, OP_READ, 0, 0, 0);
    chk("invalid_hold", -490, -890);
    step(1, OP_BAD, 777, 777, 0);
    chk("unknown_op_hold", -490, -890);
    step(1, OP_READ, 0, 0, 0);
    chk("state_unchanged", -490, -890);
    step(1, OP_SET, 1000, 1000, 3);
    step(1, OP_SET, 1000, 1000, 32'h8000_0000);
    step(1, OP_READ, 0, 0, 0);
    chk("setcoef_oob_ignored", -490, -890);
    #3 reset = 1;
    #1 chk("async_reset", 0, 0);
    @(posedge clock);
    #1 reset = 0;
    step(1, OP_READ, 0, 0, 0);
    chk("read_after_reset", 0, 0);
    step(1, OP_SET, 32767, 0, 0);
    step(1, OP_PUSH, 2, 0, 0);
    step(1, OP_READ, 0, 0, 0);
`ifdef SCIE_SATURATE_EN
    chk("overflow_sat", 32767, 0);
`else
    chk("overflow_wrap", -2, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
